// File: rtl/axi_master_bridge.sv
// axi_master_bridge: turns a single-word request port into single-beat AXI4
// read (AR/R) or write (AW/W/B) transactions, one transaction at a time.
// Optional feature: define AXI_MASTER_TIMEOUT_EN to add a response-wait
// timeout with a DRAIN state that silently absorbs the late response.

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module axi_master_bridge #(
    parameter logic [`AXI_ID_BITS-1:0] MASTER_ID      = '0,
    parameter int unsigned             TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    // core-side request / response
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [31:0]                   req_addr,
    input  logic [31:0]                   req_wdata,
    input  logic [3:0]                    req_wstrb,
    output logic                          rsp_valid,
    output logic [31:0]                   rsp_rdata,
    output logic                          rsp_err,
    // AXI read address
    output logic [`AXI_ID_BITS-1:0]       arid,
    output logic [`AXI_ADDR_BITS-1:0]     araddr,
    output logic [7:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic [1:0]                    arburst,
    output logic                          arvalid,
    input  logic                          arready,
    // AXI read data
    input  logic [`AXI_ID_BITS-1:0]       rid,
    input  logic [`AXI_DATA_BITS-1:0]     rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rlast,
    input  logic                          rvalid,
    output logic                          rready,
    // AXI write address
    output logic [`AXI_ID_BITS-1:0]       awid,
    output logic [`AXI_ADDR_BITS-1:0]     awaddr,
    output logic [7:0]                    awlen,
    output logic [2:0]                    awsize,
    output logic [1:0]                    awburst,
    output logic                          awvalid,
    input  logic                          awready,
    // AXI write data
    output logic [`AXI_DATA_BITS-1:0]     wdata,
    output logic [`AXI_DATA_BITS/8-1:0]   wstrb,
    output logic                          wlast,
    output logic                          wvalid,
    input  logic                          wready,
    // AXI write response
    input  logic [`AXI_ID_BITS-1:0]       bid,
    input  logic [1:0]                    bresp,
    input  logic                          bvalid,
    output logic                          bready
);

`ifdef AXI_MASTER_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DRAIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP} state_t;
`endif

    state_t      state_reg, state_next;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic        aw_done_reg;
    logic        w_done_reg;
    logic        rsp_valid_reg, rsp_valid_next;
    logic        rsp_err_reg, rsp_err_next;
    logic [31:0] rsp_rdata_reg, rsp_rdata_next;
    logic        accept;
    logic        aw_fire;
    logic        w_fire;

    // RID/BID/RLAST are deliberately ignored for single-beat, single-outstanding use.
    logic unused_inputs;
    assign unused_inputs = ^{rid, bid, rlast};

`ifdef AXI_MASTER_TIMEOUT_EN
    logic [31:0] wait_cnt_reg;
    logic        timed_out;
    assign timed_out = (wait_cnt_reg == 32'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    assign accept  = req_valid && req_ready;
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;

    // Channel outputs are decoded from registered state only: no req->AXI path.
    assign req_ready = (state_reg == IDLE);
    assign arvalid   = (state_reg == RADDR);
    assign awvalid   = (state_reg == WREQ) && !aw_done_reg;
    assign wvalid    = (state_reg == WREQ) && !w_done_reg;
`ifdef AXI_MASTER_TIMEOUT_EN
    assign rready    = (state_reg == RDATA) || ((state_reg == DRAIN) && !we_reg);
    assign bready    = (state_reg == WRESP) || ((state_reg == DRAIN) && we_reg);
`else
    assign rready    = (state_reg == RDATA);
    assign bready    = (state_reg == WRESP);
`endif

    assign arid    = MASTER_ID;
    assign araddr  = addr_reg;
    assign arlen   = 8'd0;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign awid    = MASTER_ID;
    assign awaddr  = addr_reg;
    assign awlen   = 8'd0;
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign wdata   = wdata_reg;
    assign wstrb   = wstrb_reg;
    assign wlast   = 1'b1;

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

    // Next-state and response decode.
    always_comb begin
        state_next     = state_reg;
        rsp_valid_next = 1'b0;
        rsp_err_next   = rsp_err_reg;
        rsp_rdata_next = rsp_rdata_reg;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = req_we ? WREQ : RADDR;
            end
            RADDR: begin
                if (arready) state_next = RDATA;
            end
            RDATA: begin
                if (rvalid) begin
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = rdata;
                    rsp_err_next   = (rresp != 2'b00);
                    state_next     = IDLE;
                end
`ifdef AXI_MASTER_TIMEOUT_EN
                else if (timed_out) begin
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = 32'd0;
                    rsp_err_next   = 1'b1;
                    state_next     = DRAIN;
                end
`endif
            end
            WREQ: begin
                if ((aw_done_reg || aw_fire) && (w_done_reg || w_fire)) state_next = WRESP;
            end
            WRESP: begin
                if (bvalid) begin
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = 32'd0;
                    rsp_err_next   = (bresp != 2'b00);
                    state_next     = IDLE;
                end
`ifdef AXI_MASTER_TIMEOUT_EN
                else if (timed_out) begin
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = 32'd0;
                    rsp_err_next   = 1'b1;
                    state_next     = DRAIN;
                end
`endif
            end
`ifdef AXI_MASTER_TIMEOUT_EN
            DRAIN: begin
                // The late response is swallowed; the client already saw the error.
                if ((we_reg && bvalid) || (!we_reg && rvalid)) state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // State register and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= 32'd0;
        end else begin
            state_reg     <= state_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_rdata_reg <= rsp_rdata_next;
        end
    end

    // Request capture at accept; payload stays stable for the whole transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_reg    <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            wstrb_reg <= 4'd0;
        end else if (accept) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            wstrb_reg <= req_wstrb;
        end
    end

    // AW and W complete independently; remember which one has handshaken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else if (state_reg == WREQ) begin
            if (aw_fire) aw_done_reg <= 1'b1;
            if (w_fire)  w_done_reg  <= 1'b1;
        end else begin
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    // Response-wait counter: restarts on any state change, counts while awaiting R/B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_reg <= 32'd0;
        end else if (state_next != state_reg) begin
            wait_cnt_reg <= 32'd0;
        end else if ((state_reg == RDATA) || (state_reg == WRESP)) begin
            wait_cnt_reg <= wait_cnt_reg + 32'd1;
        end
    end
`endif

endmodule
